// File: rtl/fetch_pc_ctrl.sv
// rtl/fetch_pc_ctrl.sv - program counter and instruction-fetch controller
module fetch_pc_ctrl #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int unsigned MAX_WAIT = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        halt,
   input  logic        branch_req,
   output logic [15:0] seq_addr,
   output logic        mux_sel,
   output logic        mux_en,
   input  logic [15:0] mux_out,
   output logic [15:0] mem_addr,
   output logic        mem_req,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   output logic [15:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [15:0] pc,
   output logic        timeout_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_HOLD = 2'b10
   } state_t;

   // Counter compare is done one bit wider so MAX_WAIT=255 cannot overflow.
   localparam logic [8:0] WAIT_LIMIT = 9'(MAX_WAIT);

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] instr_q, instr_d;
   logic        instr_valid_q, instr_valid_d;
   logic        mem_req_q, mem_req_d;
   logic        timeout_q, timeout_d;
   logic [7:0]  wait_q, wait_d;

   logic [8:0]  wait_inc;
   logic        consume;

   assign wait_inc = {1'b0, wait_q} + 9'd1;

   // The instruction is consumed in the single HOLD cycle where downstream is ready;
   // this is the only cycle the next-address mux is enabled and its output trusted.
   assign consume  = (state_q == ST_HOLD) && instr_valid_q && instr_ready;
   assign mux_en   = consume;
   assign mux_sel  = consume && branch_req;

   assign seq_addr    = pc_q + 16'd1;
   assign mem_addr    = pc_q;
   assign mem_req     = mem_req_q;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign pc          = pc_q;
   assign timeout_err = timeout_q;

   // Next-state and next-output computation for the IDLE/REQ/HOLD fetch sequence.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      mem_req_d     = mem_req_q;
      timeout_d     = timeout_q;
      wait_d        = wait_q;

      case (state_q)
         ST_IDLE: begin
            mem_req_d     = 1'b0;
            instr_valid_d = 1'b0;
            wait_d        = 8'd0;
            if (start && !halt) begin
               state_d   = ST_REQ;
               mem_req_d = 1'b1;
               timeout_d = 1'b0;
            end
         end

         ST_REQ: begin
            if (mem_ack) begin
               // An ack on the cycle the limit is reached still wins over the timeout.
               instr_d       = mem_rdata;
               instr_valid_d = 1'b1;
               mem_req_d     = 1'b0;
               wait_d        = 8'd0;
               state_d       = ST_HOLD;
            end else if (wait_inc >= WAIT_LIMIT) begin
               timeout_d = 1'b1;
               mem_req_d = 1'b0;
               wait_d    = 8'd0;
               state_d   = ST_IDLE;
            end else begin
               wait_d = wait_inc[7:0];
            end
         end

         ST_HOLD: begin
            if (consume) begin
               pc_d          = mux_out;
               instr_valid_d = 1'b0;
               wait_d        = 8'd0;
               if (halt) begin
                  mem_req_d = 1'b0;
                  state_d   = ST_IDLE;
               end else begin
                  mem_req_d = 1'b1;
                  state_d   = ST_REQ;
               end
            end
         end

         default: begin
            // Unreachable encodings fall back to a quiet IDLE.
            state_d       = ST_IDLE;
            mem_req_d     = 1'b0;
            instr_valid_d = 1'b0;
            wait_d        = 8'd0;
         end
      endcase
   end

   // State and registered outputs; reset abandons any outstanding request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= 16'h0000;
         instr_valid_q <= 1'b0;
         mem_req_q     <= 1'b0;
         timeout_q     <= 1'b0;
         wait_q        <= 8'd0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         mem_req_q     <= mem_req_d;
         timeout_q     <= timeout_d;
         wait_q        <= wait_d;
      end
   end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb/tb_fetch_pc_ctrl.sv - directed self-checking bench for fetch_pc_ctrl
module tb_fetch_pc_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        halt;
   logic        branch_req;
   logic [15:0] seq_addr;
   logic        mux_sel;
   logic        mux_en;
   logic [15:0] mux_out;
   logic [15:0] mem_addr;
   logic        mem_req;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] pc;
   logic        timeout_err;
   logic [15:0] branch_target;

   int checks;
   int errors;

   fetch_pc_ctrl #(.RESET_PC(16'h0000), .MAX_WAIT(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .halt        (halt),
      .branch_req  (branch_req),
      .seq_addr    (seq_addr),
      .mux_sel     (mux_sel),
      .mux_en      (mux_en),
      .mux_out     (mux_out),
      .mem_addr    (mem_addr),
      .mem_req     (mem_req),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .pc          (pc),
      .timeout_err (timeout_err)
   );

   // External 2:1 mux; a disabled mux presents garbage that must never reach pc.
   assign mux_out = !mux_en ? 16'hDEAD : (mux_sel ? branch_target : seq_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0; start = 1'b0; halt = 1'b0; branch_req = 1'b0;
      mem_ack = 1'b0; mem_rdata = 16'h0000; instr_ready = 1'b0; branch_target = 16'h0000;

      // Reset values
      #2;
      chk("rst_pc", pc, 16'h0000);
      chk("rst_instr", instr, 16'h0000);
      chk("rst_valid", instr_valid, 0);
      chk("rst_req", mem_req, 0);
      chk("rst_mux_en", mux_en, 0);
      chk("rst_mux_sel", mux_sel, 0);
      chk("rst_tmo", timeout_err, 0);
      chk("rst_seq", seq_addr, 16'h0001);
      step(); step();
      rst_n = 1'b1;

      // 1: sequential fetch
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t1_req", mem_req, 1);
      chk("t1_addr", mem_addr, 16'h0000);
      mem_ack = 1'b1; mem_rdata = 16'h1234;
      step();
      mem_ack = 1'b0; instr_ready = 1'b1;
      #1;
      chk("t1_instr", instr, 16'h1234);
      chk("t1_valid", instr_valid, 1);
      chk("t1_req_low", mem_req, 0);
      chk("t1_mux_en", mux_en, 1);
      chk("t1_mux_sel", mux_sel, 0);
      step();
      instr_ready = 1'b0;
      chk("t1_pc", pc, 16'h0001);
      chk("t1_valid_clr", instr_valid, 0);
      chk("t1_next_addr", mem_addr, 16'h0001);
      chk("t1_next_req", mem_req, 1);

      // 5: stall in HOLD, then 2: branch
      mem_ack = 1'b1; mem_rdata = 16'h5678;
      step();
      mem_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t5_mux_en", mux_en, 0);
         step();
         chk("t5_instr", instr, 16'h5678);
         chk("t5_pc", pc, 16'h0001);
         chk("t5_valid", instr_valid, 1);
      end
      branch_req = 1'b1; instr_ready = 1'b1; branch_target = 16'h00A0;
      #1;
      chk("t2_mux_sel", mux_sel, 1);
      chk("t2_mux_en", mux_en, 1);
      step();
      branch_req = 1'b0; instr_ready = 1'b0;
      chk("t2_pc", pc, 16'h00A0);
      chk("t2_addr", mem_addr, 16'h00A0);
      chk("t2_req", mem_req, 1);

      // 3: branch to FFFF then wrap on a sequential consume
      mem_ack = 1'b1; mem_rdata = 16'h9ABC;
      step();
      mem_ack = 1'b0; branch_req = 1'b1; instr_ready = 1'b1; branch_target = 16'hFFFF;
      step();
      branch_req = 1'b0; instr_ready = 1'b0;
      chk("t3_pc_ffff", pc, 16'hFFFF);
      chk("t3_seq_wrap", seq_addr, 16'h0000);
      mem_ack = 1'b1; mem_rdata = 16'h0F0F;
      step();
      mem_ack = 1'b0; instr_ready = 1'b1;
      #1;
      chk("t3_mux_sel", mux_sel, 0);
      step();
      instr_ready = 1'b0;
      chk("t3_pc_wrap", pc, 16'h0000);
      chk("t3_addr", mem_addr, 16'h0000);

      // 4: timeout after 8 REQ cycles, start clears it
      for (int i = 0; i < 7; i++) step();
      chk("t4_req_7", mem_req, 1);
      chk("t4_tmo_7", timeout_err, 0);
      step();
      chk("t4_req_8", mem_req, 0);
      chk("t4_tmo_8", timeout_err, 1);
      step();
      chk("t4_idle_req", mem_req, 0);
      chk("t4_sticky", timeout_err, 1);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t4_clr", timeout_err, 0);
      chk("t4_restart", mem_req, 1);

      // Ack on the same cycle the counter reaches the limit is a success
      for (int i = 0; i < 7; i++) step();
      mem_ack = 1'b1; mem_rdata = 16'h1111;
      step();
      mem_ack = 1'b0;
      chk("edge_valid", instr_valid, 1);
      chk("edge_instr", instr, 16'h1111);
      chk("edge_tmo", timeout_err, 0);

      // 6: halt at HOLD exit goes to IDLE with no new request
      halt = 1'b1; instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      chk("t6_pc", pc, 16'h0001);
      chk("t6_valid", instr_valid, 0);
      chk("t6_req", mem_req, 0);
      start = 1'b1;
      step(); step();
      start = 1'b0; halt = 1'b0;
      chk("t6_halt_start", mem_req, 0);

      // mem_ack in IDLE is ignored
      mem_ack = 1'b1; mem_rdata = 16'hFFFF;
      step();
      mem_ack = 1'b0;
      chk("idle_ack_valid", instr_valid, 0);
      chk("idle_ack_instr", instr, 16'h1111);

      // 6: async reset mid-REQ
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t6r_req", mem_req, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6r_req_rst", mem_req, 0);
      chk("t6r_pc_rst", pc, 16'h0000);
      chk("t6r_instr_rst", instr, 16'h0000);
      chk("t6r_valid_rst", instr_valid, 0);
      step();
      rst_n = 1'b1;
      step();
      chk("t6r_idle", mem_req, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
